// File: rtl/datapath_xyz_if.sv
// Command/data bundle between the operation controller and the X/Y/Z datapath.
// The controller side drives commands and the operand; the datapath side
// returns register contents and status.
interface datapath_xyz_if #(
  parameter int WIDTH = 16
);
  logic [4:0]       Tx;
  logic [4:0]       Ty;
  logic [4:0]       Tz;
  logic [4:0]       Tula;
  logic [WIDTH-1:0] entrada;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] Z;
  logic             carry;
  logic             y_zero;
  logic             z_valid;
  logic             cmd_err;

  modport master (
    output Tx, Ty, Tz, Tula, entrada,
    input  X, Y, Z, carry, y_zero, z_valid, cmd_err
  );

  modport slave (
    input  Tx, Ty, Tz, Tula, entrada,
    output X, Y, Z, carry, y_zero, z_valid, cmd_err
  );
endinterface

// File: rtl/datapath_xyz.sv
// X/Y/Z register datapath. Executes one command set per clock:
// X loads from entrada, Y from the ALU, Z from Y. Provides carry/borrow,
// a Y-is-zero flag, a one-cycle Z-loaded pulse and a sticky illegal-code flag.
module datapath_xyz #(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           reset,
  datapath_xyz_if.slave  bus
);

  localparam logic [4:0] CMD_HOLD  = 5'd0;
  localparam logic [4:0] CMD_LOAD  = 5'd1;
  localparam logic [4:0] CMD_CLEAR = 5'd2;
  localparam logic [4:0] CMD_SHR   = 5'd3;
  localparam logic [4:0] CMD_SHL   = 5'd4;

  localparam logic [4:0] ALU_PASS = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_AND  = 5'd3;

  // Register command codes above SHL are reserved.
  function automatic logic reg_cmd_legal(input logic [4:0] cmd);
    return (cmd <= CMD_SHL);
  endfunction

  // Next value of a register under a command; reserved codes hold.
  function automatic logic [WIDTH-1:0] reg_op(
    input logic [4:0]       cmd,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] src
  );
    logic [WIDTH-1:0] res;
    case (cmd)
      CMD_HOLD:  res = cur;
      CMD_LOAD:  res = src;
      CMD_CLEAR: res = '0;
      CMD_SHR:   res = {1'b0, cur[WIDTH-1:1]};
      CMD_SHL:   res = {cur[WIDTH-2:0], 1'b0};
      default:   res = cur;
    endcase
    return res;
  endfunction

  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] y_r;
  logic [WIDTH-1:0] z_r;
  logic             carry_r;
  logic             z_valid_r;
  logic             cmd_err_r;

  logic [WIDTH-1:0] alu_res_s;
  logic             alu_cout_s;
  logic             alu_ok_s;
  logic [WIDTH:0]   alu_wide_s;

  logic [WIDTH-1:0] y_next_s;
  logic             carry_next_s;
  logic             illegal_s;

  // ALU on the current (pre-edge) X and Y; the extra bit holds carry or borrow.
  always_comb begin
    alu_wide_s = '0;
    alu_res_s  = y_r;
    alu_cout_s = 1'b0;
    alu_ok_s   = 1'b1;
    case (bus.Tula)
      ALU_PASS: begin
        alu_res_s = x_r;
      end
      ALU_ADD: begin
        alu_wide_s = {1'b0, y_r} + {1'b0, x_r};
        alu_res_s  = alu_wide_s[WIDTH-1:0];
        alu_cout_s = alu_wide_s[WIDTH];
      end
      ALU_SUB: begin
        // Top bit of the widened difference is set exactly when y < x.
        alu_wide_s = {1'b0, y_r} - {1'b0, x_r};
        alu_res_s  = alu_wide_s[WIDTH-1:0];
        alu_cout_s = alu_wide_s[WIDTH];
      end
      ALU_AND: begin
        alu_res_s = y_r & x_r;
      end
      default: begin
        alu_ok_s = 1'b0;
      end
    endcase
  end

  // Y and carry next-state: an illegal ALU select on a Y load freezes both.
  always_comb begin
    y_next_s     = y_r;
    carry_next_s = carry_r;
    case (bus.Ty)
      CMD_LOAD: begin
        if (alu_ok_s) begin
          y_next_s     = alu_res_s;
          carry_next_s = alu_cout_s;
        end else begin
          y_next_s     = y_r;
          carry_next_s = carry_r;
        end
      end
      CMD_CLEAR: begin
        y_next_s     = '0;
        carry_next_s = 1'b0;
      end
      default: begin
        y_next_s     = reg_op(bus.Ty, y_r, alu_res_s);
        carry_next_s = carry_r;
      end
    endcase
  end

  // Any reserved register code, or a reserved ALU select used by a Y load.
  always_comb begin
    illegal_s = !reg_cmd_legal(bus.Tx) || !reg_cmd_legal(bus.Ty) ||
                !reg_cmd_legal(bus.Tz) ||
                ((bus.Ty == CMD_LOAD) && !alu_ok_s);
  end

  // State registers; reset wins over every command in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= '0;
      carry_r   <= 1'b0;
      z_valid_r <= 1'b0;
      cmd_err_r <= 1'b0;
    end else begin
      x_r       <= reg_op(bus.Tx, x_r, bus.entrada);
      y_r       <= y_next_s;
      z_r       <= reg_op(bus.Tz, z_r, y_r);
      carry_r   <= carry_next_s;
      z_valid_r <= (bus.Tz == CMD_LOAD);
      cmd_err_r <= cmd_err_r | illegal_s;
    end
  end

  assign bus.X       = x_r;
  assign bus.Y       = y_r;
  assign bus.Z       = z_r;
  assign bus.carry   = carry_r;
  assign bus.y_zero  = (y_r == '0);
  assign bus.z_valid = z_valid_r;
  assign bus.cmd_err = cmd_err_r;

endmodule

// File: tb/tb_datapath_xyz.sv
// Directed bench for datapath_xyz. Stimulus drives one command set per cycle
// and queues the hand-computed post-edge state; a monitor pops and compares
// after every rising edge.
module tb_datapath_xyz;

  localparam int W = 16;

  typedef struct {
    int         idx;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
    logic       c;
    logic       yz;
    logic       zv;
    logic       e;
  } exp_t;

  logic clk;
  logic reset;
  exp_t exp_q[$];
  int   n_vec;
  int   n_miss;
  int   vec_id;

  datapath_xyz_if #(.WIDTH(W)) bus ();

  datapath_xyz #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: after each edge, compare the DUT state with the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec = n_vec + 1;
      if (bus.X !== e.x || bus.Y !== e.y || bus.Z !== e.z ||
          bus.carry !== e.c || bus.y_zero !== e.yz ||
          bus.z_valid !== e.zv || bus.cmd_err !== e.e) begin
        n_miss = n_miss + 1;
        $display("FAIL vec%0d: got X=%h Y=%h Z=%h c=%b yz=%b zv=%b err=%b, want X=%h Y=%h Z=%h c=%b yz=%b zv=%b err=%b",
                 e.idx, bus.X, bus.Y, bus.Z, bus.carry, bus.y_zero,
                 bus.z_valid, bus.cmd_err,
                 e.x, e.y, e.z, e.c, e.yz, e.zv, e.e);
      end
    end
  end

  // Apply one command set before the next edge and queue the expected result.
  task automatic vec(input logic rst, input logic [4:0] tx, input logic [4:0] ty,
                     input logic [4:0] tz, input logic [4:0] tula,
                     input logic [W-1:0] ent,
                     input logic [W-1:0] ex, input logic [W-1:0] ey,
                     input logic [W-1:0] ez, input logic ec, input logic ezv,
                     input logic ee);
    exp_t e;
    @(negedge clk);
    reset       = rst;
    bus.Tx      = tx;
    bus.Ty      = ty;
    bus.Tz      = tz;
    bus.Tula    = tula;
    bus.entrada = ent;
    e.idx = vec_id;
    e.x   = ex;
    e.y   = ey;
    e.z   = ez;
    e.c   = ec;
    e.yz  = (ey == 16'h0000);
    e.zv  = ezv;
    e.e   = ee;
    exp_q.push_back(e);
    vec_id = vec_id + 1;
  endtask

  initial begin
    n_vec       = 0;
    n_miss      = 0;
    vec_id      = 0;
    reset       = 1'b1;
    bus.Tx      = 5'd0;
    bus.Ty      = 5'd0;
    bus.Tz      = 5'd0;
    bus.Tula    = 5'd0;
    bus.entrada = 16'h0000;

    //   rst   Tx     Ty     Tz     Tula   entrada    X         Y         Z         c     zv    err
    vec(1'b1, 5'd0,  5'd0,  5'd0,  5'd0,  16'h0000,  16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    // load X, clear Y and Z
    vec(1'b0, 5'd1,  5'd2,  5'd2,  5'd0,  16'h0005,  16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    // simultaneous X and Y load: Y uses old X
    vec(1'b0, 5'd1,  5'd1,  5'd0,  5'd1,  16'h0007,  16'h0007, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0);
    vec(1'b0, 5'd2,  5'd1,  5'd0,  5'd1,  16'h0000,  16'h0000, 16'h000C, 16'h0000, 1'b0, 1'b0, 1'b0);
    // set up X=1, Y=FFFF, then add wraps to zero with carry
    vec(1'b0, 5'd1,  5'd2,  5'd0,  5'd0,  16'hFFFF,  16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    vec(1'b0, 5'd1,  5'd1,  5'd0,  5'd0,  16'h0001,  16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0);
    vec(1'b0, 5'd0,  5'd1,  5'd0,  5'd1,  16'h0000,  16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    // X=3, Y=1 then subtract with borrow
    vec(1'b0, 5'd1,  5'd1,  5'd0,  5'd0,  16'h0003,  16'h0003, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0);
    vec(1'b0, 5'd0,  5'd1,  5'd0,  5'd2,  16'h0000,  16'h0003, 16'hFFFE, 16'h0000, 1'b1, 1'b0, 1'b0);
    // FFFE + 8005 = 1_8003: Y=8003 with carry 1
    vec(1'b0, 5'd1,  5'd0,  5'd0,  5'd0,  16'h8005,  16'h8005, 16'hFFFE, 16'h0000, 1'b1, 1'b0, 1'b0);
    vec(1'b0, 5'd0,  5'd1,  5'd0,  5'd1,  16'h0000,  16'h8005, 16'h8003, 16'h0000, 1'b1, 1'b0, 1'b0);
    // shifts on Y leave carry alone
    vec(1'b0, 5'd0,  5'd3,  5'd0,  5'd0,  16'h0000,  16'h8005, 16'h4001, 16'h0000, 1'b1, 1'b0, 1'b0);
    vec(1'b0, 5'd0,  5'd4,  5'd0,  5'd0,  16'h0000,  16'h8005, 16'h8002, 16'h0000, 1'b1, 1'b0, 1'b0);
    // Z loads back to back, then z_valid drops
    vec(1'b0, 5'd0,  5'd0,  5'd1,  5'd0,  16'h0000,  16'h8005, 16'h8002, 16'h8002, 1'b1, 1'b1, 1'b0);
    vec(1'b0, 5'd0,  5'd0,  5'd1,  5'd0,  16'h0000,  16'h8005, 16'h8002, 16'h8002, 1'b1, 1'b1, 1'b0);
    vec(1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  16'h0000,  16'h8005, 16'h8002, 16'h8002, 1'b1, 1'b0, 1'b0);
    // X and Z shifts, bit shifted out is lost
    vec(1'b0, 5'd3,  5'd0,  5'd3,  5'd0,  16'h0000,  16'h4002, 16'h8002, 16'h4001, 1'b1, 1'b0, 1'b0);
    vec(1'b0, 5'd4,  5'd0,  5'd4,  5'd0,  16'h0000,  16'h8004, 16'h8002, 16'h8002, 1'b1, 1'b0, 1'b0);
    // clear Y clears carry
    vec(1'b0, 5'd0,  5'd2,  5'd2,  5'd0,  16'h0000,  16'h8004, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    // illegal Tx holds X and sets sticky error
    vec(1'b0, 5'd1,  5'd0,  5'd0,  5'd0,  16'h0004,  16'h0004, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    vec(1'b0, 5'd9,  5'd0,  5'd0,  5'd0,  16'h1234,  16'h0004, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    vec(1'b0, 5'd0,  5'd0,  5'd0,  5'd0,  16'h0000,  16'h0004, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    vec(1'b0, 5'd1,  5'd0,  5'd0,  5'd3,  16'h0005,  16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    vec(1'b0, 5'd0,  5'd2,  5'd0,  5'd0,  16'h0000,  16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    // reset clears error
    vec(1'b1, 5'd0,  5'd0,  5'd0,  5'd0,  16'h0000,  16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    // bad ALU select without a Y load is harmless
    vec(1'b0, 5'd0,  5'd0,  5'd0,  5'd7,  16'h0000,  16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    // build Y=2 with carry=1 (FFFF + 3)
    vec(1'b0, 5'd1,  5'd0,  5'd0,  5'd0,  16'hFFFF,  16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    vec(1'b0, 5'd1,  5'd1,  5'd0,  5'd0,  16'h0003,  16'h0003, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0);
    vec(1'b0, 5'd0,  5'd1,  5'd0,  5'd1,  16'h0000,  16'h0003, 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b0);
    // Y load with bad ALU select: Y and carry hold, error set
    vec(1'b0, 5'd0,  5'd1,  5'd0,  5'd6,  16'h0000,  16'h0003, 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b1);
    vec(1'b0, 5'd0,  5'd5,  5'd0,  5'd0,  16'h0000,  16'h0003, 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b1);
    vec(1'b0, 5'd0,  5'd0,  5'd31, 5'd0,  16'h0000,  16'h0003, 16'h0002, 16'h0000, 1'b1, 1'b0, 1'b1);
    vec(1'b1, 5'd0,  5'd0,  5'd0,  5'd0,  16'h0000,  16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    // Z load raises z_valid, then reset with all loads requested wins
    vec(1'b0, 5'd0,  5'd0,  5'd1,  5'd0,  16'h0000,  16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    vec(1'b1, 5'd1,  5'd1,  5'd1,  5'd1,  16'hAAAA,  16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    vec(1'b0, 5'd1,  5'd0,  5'd0,  5'd0,  16'hAAAA,  16'hAAAA, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    // drain the scoreboard within a bounded number of cycles
    @(negedge clk);
    bus.Tx = 5'd0;
    bus.Ty = 5'd0;
    bus.Tz = 5'd0;
    bus.Tula = 5'd0;
    for (int i = 0; i < 5; i++) begin
      if (exp_q.size() != 0) @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      n_miss = n_miss + 1;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
